// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, default geometry and derived-size helpers
// for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int          DEF_ADDR_W     = 32;
  localparam int          DEF_LINE_WORDS = 4;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REFILL = 2'd1,
    ST_RELOOK = 2'd2
  } fetch_state_e;

  // Bytes covered by one cache line (LINE_BYTES).
  function automatic int line_bytes(input int line_words);
    return 4 * line_words;
  endfunction

  // Width of the word index within a line (IDX_W).
  function automatic int idx_width(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/line_refill.sv
// line_refill: walks one cache line from word 0 upward, requesting each word
// from instruction memory and forwarding every acknowledged beat to the icache.
module line_refill
  import fetch_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W      = idx_width(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              active,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [31:0]       fill_data,
  output logic [ADDR_W-1:0] fill_tag_addr,
  output logic              done
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              beat;

  // An ack only counts while a refill is actually in flight.
  assign beat = active & mem_ack;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (start) begin
      base_d = base_addr;
      cnt_d  = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_req       = active;
  assign mem_addr      = base_q + (ADDR_W'(cnt_q) << 2);
  assign fill_we       = beat;
  assign fill_idx      = cnt_q;
  assign fill_data     = mem_data;
  assign fill_tag_addr = base_q;
  assign done          = beat && (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, the IF/ID valid/PC
// pair and the miss -> refill -> re-lookup FSM. Miss counter: FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter  int                ADDR_W     = DEF_ADDR_W,
  parameter  int                LINE_WORDS = DEF_LINE_WORDS,
  parameter  logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  localparam int                IDX_W      = idx_width(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] addr_branch,
  input  logic              hit,
  output logic [ADDR_W-1:0] lookup_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [31:0]       fill_data,
  output logic [ADDR_W-1:0] fill_tag_addr,
  output logic              valid_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       miss_count
);

  localparam int                LINE_BYTES = line_bytes(LINE_WORDS);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic              valid_q, valid_d;
  logic              redirect_pend_q, redirect_pend_d;
  logic [ADDR_W-1:0] branch_tgt;
  logic              refill_start;
  logic              refill_active;
  logic              refill_done;

  assign branch_tgt    = addr_branch & WORD_MASK;
  assign refill_active = (state_q == ST_REFILL);

  // A redirect always wins; in RUN it squashes, during a refill it is parked
  // until the line is complete, and in RELOOK it beats any parked redirect.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_out_d        = pc_out_q;
    valid_d         = valid_q;
    redirect_pend_d = redirect_pend_q;
    redirect_addr_d = redirect_addr_q;
    refill_start    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (PCSrc) begin
          pc_d    = branch_tgt;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (!hit) begin
          refill_start = 1'b1;
          valid_d      = 1'b0;
          state_d      = ST_REFILL;
        end else begin
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
        end
      end
      ST_REFILL: begin
        valid_d = 1'b0;
        if (PCSrc) begin
          redirect_pend_d = 1'b1;
          redirect_addr_d = branch_tgt;
        end
        if (refill_done) begin
          state_d = ST_RELOOK;
        end
      end
      ST_RELOOK: begin
        redirect_pend_d = 1'b0;
        if (PCSrc) begin
          pc_d = branch_tgt;
        end else if (redirect_pend_q) begin
          pc_d = redirect_addr_q;
        end
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      pc_out_q        <= '0;
      valid_q         <= 1'b0;
      redirect_pend_q <= 1'b0;
      redirect_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_out_q        <= pc_out_d;
      valid_q         <= valid_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

  line_refill #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_refill (
    .clk           (clk),
    .reset         (reset),
    .start         (refill_start),
    .active        (refill_active),
    .base_addr     (pc_q & LINE_MASK),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .fill_we       (fill_we),
    .fill_idx      (fill_idx),
    .fill_data     (fill_data),
    .fill_tag_addr (fill_tag_addr),
    .done          (refill_done)
  );

  assign lookup_addr = pc_q;
  assign valid_out   = valid_q;
  assign pc_out      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counts RUN->REFILL transitions, sticking at all-ones.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (refill_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run checked against an
// architectural fetch-stream model and a small direct-mapped icache model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        PCSrc;
  logic [31:0] addr_branch;
  logic        hit;
  logic [31:0] lookup_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic [31:0] fill_tag_addr;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] miss_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        use_model = 1'b0;
  logic        hit_drv;
  logic [31:0] mem_data_drv;
  logic        flush_req = 1'b0;
  logic [27:0] tag_arr [16];
  logic        line_ok [16];
  logic        model_hit;

  fetch_ctrl #(
    .ADDR_W     (32),
    .LINE_WORDS (4),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .PCSrc         (PCSrc),
    .addr_branch   (addr_branch),
    .hit           (hit),
    .lookup_addr   (lookup_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .fill_we       (fill_we),
    .fill_idx      (fill_idx),
    .fill_data     (fill_data),
    .fill_tag_addr (fill_tag_addr),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign model_hit = line_ok[lookup_addr[7:4]] && (tag_arr[lookup_addr[7:4]] == lookup_addr[31:4]);
  assign hit       = use_model ? model_hit : hit_drv;
  assign mem_data  = use_model ? beat_data(mem_addr) : mem_data_drv;

  // Behavioural icache: a line becomes valid once its last word is written.
  always @(posedge clk) begin
    if (flush_req) begin
      for (int i = 0; i < 16; i++) line_ok[i] <= 1'b0;
    end else if (fill_we && fill_idx == 2'd3) begin
      line_ok[fill_tag_addr[7:4]] <= 1'b1;
      tag_arr[fill_tag_addr[7:4]] <= fill_tag_addr[31:4];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; hit_drv = 1'b1;
    mem_ack = 1'b0; addr_branch = '0; mem_data_drv = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    PCSrc = 1'b1; addr_branch = a;
    step();
    PCSrc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; hit_drv = 1'b1;
    mem_ack = 1'b0; addr_branch = '0; mem_data_drv = '0;
    step();
    step();
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b want 0", valid_out); end
    tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc_out: got %h want 0", pc_out); end
    tests_run++; if (lookup_addr !== RESET_PC) begin tests_failed++; $display("[TB] FAIL reset_lookup: got %h want %h", lookup_addr, RESET_PC); end
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
    tests_run++; if (miss_count !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_miss_count: got %h want 0", miss_count); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL seq_valid[%0d]: got %b want 1", i, valid_out); end
      tests_run++; if (pc_out !== 32'(4 * i)) begin tests_failed++; $display("[TB] FAIL seq_pc_out[%0d]: got %h want %h", i, pc_out, 32'(4 * i)); end
    end
  endtask

  task automatic test_miss_refill();
    logic [31:0] exp_miss;
    do_reset();
    goto_pc(32'h24);
    tests_run++; if (lookup_addr !== 32'h24) begin tests_failed++; $display("[TB] FAIL miss_lookup: got %h want 24", lookup_addr); end
    hit_drv = 1'b0;
    step();
    tests_run++; if (mem_req !== 1'b1 || valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL miss_enter: got req=%b valid=%b want req=1 valid=0", mem_req, valid_out); end
    for (int b = 0; b < 4; b++) begin
      mem_ack = 1'b0;
      #1;
      tests_run++; if (fill_we !== 1'b0 || mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL miss_idle[%0d]: got we=%b req=%b want we=0 req=1", b, fill_we, mem_req); end
      step();
      mem_ack = 1'b1; mem_data_drv = 32'hD000_0000 + 32'(b);
      #1;
      tests_run++; if (mem_addr !== 32'h20 + 32'(4 * b)) begin tests_failed++; $display("[TB] FAIL miss_mem_addr[%0d]: got %h want %h", b, mem_addr, 32'h20 + 32'(4 * b)); end
      tests_run++; if (fill_we !== 1'b1 || fill_idx !== 2'(b) || fill_data !== 32'hD000_0000 + 32'(b) || fill_tag_addr !== 32'h20) begin
        tests_failed++; $display("[TB] FAIL miss_fill[%0d]: got we=%b idx=%0d data=%h tag=%h want we=1 idx=%0d data=%h tag=20", b, fill_we, fill_idx, fill_data, fill_tag_addr, b, 32'hD000_0000 + 32'(b));
      end
      step();
      mem_ack = 1'b0;
    end
    tests_run++; if (mem_req !== 1'b0 || lookup_addr !== 32'h24) begin tests_failed++; $display("[TB] FAIL miss_relook: got req=%b lookup=%h want req=0 lookup=24", mem_req, lookup_addr); end
    hit_drv = 1'b1;
    step();
    tests_run++; if (lookup_addr !== 32'h24 || valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL miss_run_lookup: got lookup=%h valid=%b want 24/0", lookup_addr, valid_out); end
    step();
    tests_run++; if (valid_out !== 1'b1 || pc_out !== 32'h24) begin tests_failed++; $display("[TB] FAIL miss_issue: got valid=%b pc_out=%h want 1/24", valid_out, pc_out); end
`ifdef FETCH_PERF_CNT_EN
    exp_miss = 32'd1;
`else
    exp_miss = 32'd0;
`endif
    tests_run++; if (miss_count !== exp_miss) begin tests_failed++; $display("[TB] FAIL miss_count_after_miss: got %0d want %0d", miss_count, exp_miss); end
  endtask

  task automatic test_branch_squash();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    tests_run++; if (lookup_addr !== 32'h10 || pc_out !== 32'hC) begin tests_failed++; $display("[TB] FAIL br_setup: got lookup=%h pc_out=%h want 10/c", lookup_addr, pc_out); end
    PCSrc = 1'b1; addr_branch = 32'h103; stall = 1'b1;
    step();
    PCSrc = 1'b0; stall = 1'b0;
    tests_run++; if (valid_out !== 1'b0 || lookup_addr !== 32'h100) begin tests_failed++; $display("[TB] FAIL br_squash: got valid=%b lookup=%h want 0/100", valid_out, lookup_addr); end
    step();
    tests_run++; if (valid_out !== 1'b1 || pc_out !== 32'h100) begin tests_failed++; $display("[TB] FAIL br_target_issue: got valid=%b pc_out=%h want 1/100", valid_out, pc_out); end
  endtask

  task automatic test_redirect_during_refill();
    do_reset();
    goto_pc(32'h40);
    hit_drv = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      mem_ack = 1'b1; mem_data_drv = 32'hBEEF_0000 + 32'(b);
      PCSrc = (b == 1); addr_branch = 32'h80;
      #1;
      tests_run++; if (fill_we !== 1'b1 || fill_idx !== 2'(b) || mem_addr !== 32'h40 + 32'(4 * b) || fill_tag_addr !== 32'h40 || valid_out !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL redir_beat[%0d]: got we=%b idx=%0d addr=%h tag=%h valid=%b want 1/%0d/%h/40/0", b, fill_we, fill_idx, mem_addr, fill_tag_addr, valid_out, b, 32'h40 + 32'(4 * b));
      end
      step();
      PCSrc = 1'b0;
    end
    mem_ack = 1'b0;
    tests_run++; if (mem_req !== 1'b0 || lookup_addr !== 32'h40) begin tests_failed++; $display("[TB] FAIL redir_relook: got req=%b lookup=%h want 0/40", mem_req, lookup_addr); end
    hit_drv = 1'b1;
    step();
    tests_run++; if (lookup_addr !== 32'h80) begin tests_failed++; $display("[TB] FAIL redir_lookup: got %h want 80", lookup_addr); end
    step();
    tests_run++; if (valid_out !== 1'b1 || pc_out !== 32'h80) begin tests_failed++; $display("[TB] FAIL redir_issue: got valid=%b pc_out=%h want 1/80", valid_out, pc_out); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || lookup_addr !== 32'h8) begin
        tests_failed++; $display("[TB] FAIL stall_hold[%0d]: got valid=%b pc_out=%h lookup=%h want 1/4/8", i, valid_out, pc_out, lookup_addr);
      end
    end
    stall = 1'b0;
    step();
    tests_run++; if (pc_out !== 32'h8) begin tests_failed++; $display("[TB] FAIL stall_resume0: got %h want 8", pc_out); end
    step();
    tests_run++; if (pc_out !== 32'hC) begin tests_failed++; $display("[TB] FAIL stall_resume1: got %h want c", pc_out); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] exp_miss;
    do_reset();
    hit_drv = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    #1;
    tests_run++; if (mem_req !== 1'b0 || fill_we !== 1'b0 || lookup_addr !== RESET_PC || valid_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rst_mid_refill: got req=%b we=%b lookup=%h valid=%b want 0/0/%h/0", mem_req, fill_we, lookup_addr, valid_out, RESET_PC);
    end
    tests_run++; if (miss_count !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_miss_count: got %0d want 0", miss_count); end
    reset = 1'b0; mem_ack = 1'b0;
    step();
`ifdef FETCH_PERF_CNT_EN
    exp_miss = 32'd1;
`else
    exp_miss = 32'd0;
`endif
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_restart: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    tests_run++; if (miss_count !== exp_miss) begin tests_failed++; $display("[TB] FAIL rst_next_miss_count: got %0d want %0d", miss_count, exp_miss); end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, prev_pc, tgt_prev, line, exp_miss;
    logic        prev_valid, pcsrc_prev, prev_req, last_final;
    int          beat_exp, emissions, rises;
    use_model = 1'b1; flush_req = 1'b1;
    reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; mem_ack = 1'b0; addr_branch = '0;
    step();
    step();
    flush_req = 1'b0; reset = 1'b0;
    exp_next = RESET_PC; prev_pc = '0; prev_valid = 1'b0; pcsrc_prev = 1'b0; tgt_prev = '0;
    prev_req = 1'b0; last_final = 1'b0; beat_exp = 0; emissions = 0; rises = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (valid_out && (!prev_valid || pc_out != prev_pc)) begin
        emissions++;
        tests_run++; if (pc_out !== exp_next) begin tests_failed++; $display("[TB] FAIL rnd_stream@%0d: got %h want %h", cyc, pc_out, exp_next); end
        exp_next = pc_out + 32'd4;
      end
      if (pcsrc_prev) exp_next = tgt_prev;
      prev_valid = valid_out; prev_pc = pc_out;
      stall       = ($urandom_range(0, 4) == 0);
      PCSrc       = ($urandom_range(0, 24) == 0);
      addr_branch = 32'($urandom_range(0, 1023));
      mem_ack     = 1'($urandom_range(0, 1));
      flush_req   = ($urandom_range(0, 199) == 0);
      pcsrc_prev  = PCSrc;
      tgt_prev    = addr_branch & ~32'h3;
      #1;
      line = lookup_addr & ~32'hF;
      if (last_final) begin
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_req_drop@%0d: got %b want 0", cyc, mem_req); end
      end
      if (mem_req && !prev_req) rises++;
      prev_req = mem_req;
      tests_run++; if (fill_we !== (mem_req & mem_ack)) begin tests_failed++; $display("[TB] FAIL rnd_fill_we@%0d: got %b want %b", cyc, fill_we, mem_req & mem_ack); end
      if (mem_req) begin
        tests_run++; if (mem_addr !== line + 32'(4 * beat_exp)) begin tests_failed++; $display("[TB] FAIL rnd_mem_addr@%0d: got %h want %h", cyc, mem_addr, line + 32'(4 * beat_exp)); end
      end
      if (fill_we) begin
        tests_run++; if (fill_idx !== 2'(beat_exp) || fill_tag_addr !== line || fill_data !== beat_data(line + 32'(4 * beat_exp))) begin
          tests_failed++; $display("[TB] FAIL rnd_fill@%0d: got idx=%0d tag=%h data=%h want %0d/%h/%h", cyc, fill_idx, fill_tag_addr, fill_data, beat_exp, line, beat_data(line + 32'(4 * beat_exp)));
        end
      end
      last_final = 1'b0;
      if (mem_req && mem_ack) begin
        if (beat_exp == 3) begin beat_exp = 0; last_final = 1'b1; end
        else beat_exp++;
      end
    end
    tests_run++; if (emissions < 30) begin tests_failed++; $display("[TB] FAIL rnd_progress: got %0d issued want >= 30", emissions); end
`ifdef FETCH_PERF_CNT_EN
    exp_miss = 32'(rises);
`else
    exp_miss = 32'd0;
`endif
    tests_run++; if (miss_count !== exp_miss) begin tests_failed++; $display("[TB] FAIL rnd_miss_count: got %0d want %0d", miss_count, exp_miss); end
    use_model = 1'b0; stall = 1'b0; PCSrc = 1'b0; mem_ack = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_branch_squash();
    test_redirect_during_refill();
    test_stall_hold();
    test_reset_mid_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
